rvj1_lsu: RTL
=============

# rvj1_lsu

Load/store unit that drives the single-cycle-request data-memory port, acting as the initiator that issues `req`/`we` and consumes `rvalid`/`wvalid`/`err`. It sits between the core execute stage and the byte-write SRAM data port. It handles one access at a time:

- generates byte enables and replicated write data for byte, half and word stores;
- aligns and sign/zero-extends load data;
- reports bus errors and response timeouts back to the core.

## Interface
Parameters:
- `DATA_WIDTH`, 32, bus data/address width; only 32 is supported.
- `TIMEOUT_CYCLES`, 16, maximum number of WAIT cycles before an access is reported as an error; minimum value 2.

Ports:
- `clk_i` in 1 — clock. There is one clock; all logic is on the rising edge.
- `rst_i` in 1 — reset, synchronous, active-high.
- `ctrl_valid_i` in 1 — core presents an access.
- `ctrl_ready_o` out 1 — LSU accepts the access. High only in IDLE.
- `ctrl_cmd_i` in 1 — `lsu_cmd_e`: LOAD=0, STORE=1.
- `ctrl_size_i` in 2 — `lsu_size_e`: B=0, H=1, W=2. Encoding 3 is treated as W.
- `ctrl_unsigned_i` in 1 — zero-extend the load result.
- `ctrl_addr_i` in 32 — byte address.
- `ctrl_wdata_i` in 32 — store data, right-aligned.
- `rsp_valid_o` out 1 — one-cycle completion pulse.
- `rsp_rdata_o` out 32 — extended load data. 0 for stores and on error.
- `rsp_err_o` out 1 — access failed; qualified by `rsp_valid_o`.
- `req_o` out 1 — memory request.
- `addr_o` out 32 — word-aligned address, bits [1:0] = 0.
- `we_o` out 4 — byte write enables; 0 for loads.
- `wdata_o` out 32 — lane-replicated store data.
- `rvalid_i` in 1 — read data valid, one cycle after `req`.
- `rdata_i` in 32 — memory read data.
- `wvalid_i` in 1 — write complete, one cycle after a nonzero `we`.
- `err_i` in 1 — bus error, one cycle after `req`.

## Operation
FSM states are IDLE, REQ, WAIT and RESP; all outputs are registered.

- **IDLE.**
  - `ctrl_ready_o` = 1.
  - On `ctrl_valid_i`, latch cmd, size, unsigned, `addr[1:0]` and formatted store data, then go to REQ.
  - If the misalignment check is compiled in and the access is misaligned, go to RESP with error and issue no `req`.
- **REQ.**
  - `req_o` = 1 for exactly one cycle; `addr_o`, `we_o` and `wdata_o` are valid in that cycle.
  - Next state is WAIT, which clears the timeout counter.
- **WAIT.**
  - `req_o` = 0 and `we_o` = 0.
  - A load completes on `rvalid_i`. A store completes on `wvalid_i`; `rvalid_i` is ignored for stores.
  - `err_i` high in any WAIT cycle completes the access with error.
  - If the counter reaches `TIMEOUT_CYCLES` with no completion, the access completes with error.
  - On any completion, go to RESP.
- **RESP.** `rsp_valid_o` = 1 for one cycle, then return to IDLE.

Store formatting:
- SB: `we` = 4'b0001 shifted left by `addr[1:0]`; `wdata` = byte replicated ×4.
- SH: `we` = 4'b0011 shifted left by `{addr[1],1'b0}`; `wdata` = half replicated ×2.
- SW: `we` = 4'hF; `wdata` = data unchanged.

Load formatting:
- Shift `rdata_i` right by 8×offset, where offset is `addr[1:0]` for B, `{addr[1],0}` for H, and 0 for W.
- Sign-extend from bit 7 or bit 15, or zero-extend when `unsigned` is set.

Boundary conditions:
- A response in IDLE, REQ or RESP is ignored.
- `err_i` and `rvalid_i` arriving in the same cycle give an error with `rsp_rdata_o` = 0.
- `rst_i` mid-access returns the FSM to IDLE, and any late memory response is ignored.

## Timing
- Reset values: `ctrl_ready_o` = 1 and every other output = 0, on the first edge where `rst_i` is sampled high.
- Nominal access, accepted in cycle N:
  - `req_o` in N+1;
  - `rvalid_i`/`wvalid_i` in N+2;
  - `rsp_valid_o` in N+3;
  - `ctrl_ready_o` back high in N+4.
- Throughput is one access per 4 cycles.
- Timeout: `rsp_valid_o` with `rsp_err_o` in cycle N+2+`TIMEOUT_CYCLES`.
- Misaligned reject: `rsp_valid_o` in N+1.

## Configuration
- `RVJ1_LSU_MISALIGN_CHECK_EN` defined:
  - An H access with `addr[0]` = 1, or a W access with `addr[1:0]` ≠ 0, is rejected with `rsp_err_o` = 1.
  - No `req_o` is issued for a rejected access.
- Undefined:
  - Misaligned offset bits are truncated to natural alignment: H uses `{addr[1],0}`, W uses offset 0.
  - The access proceeds normally.

## Structure
- `rvj1_lsu_pkg` holds `lsu_cmd_e`, `lsu_size_e`, `lsu_state_e` and the `TIMEOUT_CYCLES` default constant.
- Sub-module `rvj1_lsu_load_align` is purely combinational: it takes `rdata`, offset, size and unsigned, and produces the extended result.
- The FSM, timeout counter and store formatting live in `rvj1_lsu`.

## Test plan
- LW at `0x100`, memory returns `0xDEADBEEF` -> `req_o` at N+1 with `addr_o` = `0x100`, `we_o` = 0; `rsp_rdata_o` = `0xDEADBEEF` at N+3, `rsp_err_o` = 0.
- LB at `0x103`, then LBU at `0x103`, with rdata `0x80FF1234` -> `0xFFFFFF80`, then `0x00000080`.
- SH of `0x0000ABCD` at `0x102` -> `we_o` = 4'b1100, `wdata_o` = `0xABCDABCD`; completion on `wvalid_i`; `rsp_rdata_o` = 0.
- Responder holds `rvalid_i`/`wvalid_i` low with `TIMEOUT_CYCLES` = 4 -> `rsp_valid_o` = 1 and `rsp_err_o` = 1 at N+6; `ctrl_ready_o` = 1 at N+7.
- With the macro defined, LW at `0x101` -> no `req_o`; `rsp_err_o` = 1 at N+1. Without the macro -> `req_o` with `addr_o` = `0x100`, normal load.
- `rst_i` asserted in WAIT, then `rvalid_i` arrives -> FSM in IDLE, no `rsp_valid_o`, `ctrl_ready_o` = 1.

Source files
------------

// File: rtl/rvj1_lsu_pkg.sv
// Shared types and defaults for the rvj1 load/store unit.
package rvj1_lsu_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

    typedef enum logic {
        LSU_LOAD  = 1'b0,
        LSU_STORE = 1'b1
    } lsu_cmd_e;

    typedef enum logic [1:0] {
        LSU_B = 2'd0,
        LSU_H = 2'd1,
        LSU_W = 2'd2
    } lsu_size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Size encoding 3 behaves as a word access.
    function automatic lsu_size_e norm_size(input logic [1:0] raw);
        return (raw == 2'd3) ? LSU_W : lsu_size_e'(raw);
    endfunction

endpackage

// File: rtl/rvj1_lsu_load_align.sv
// Combinational load-data aligner: picks the addressed byte/half/word and extends it.
module rvj1_lsu_load_align
    import rvj1_lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  lsu_size_e   size,
    input  logic        is_unsigned,
    output logic [31:0] result
);

    logic [1:0]  eff_off;
    logic [31:0] shifted;

    always_comb begin
        eff_off = 2'd0;
        case (size)
            LSU_B:   eff_off = offset;
            LSU_H:   eff_off = {offset[1], 1'b0};
            default: eff_off = 2'd0;
        endcase
        shifted = rdata >> {eff_off, 3'b000};
        result  = shifted;
        case (size)
            LSU_B:   result = {{24{shifted[7] & ~is_unsigned}}, shifted[7:0]};
            LSU_H:   result = {{16{shifted[15] & ~is_unsigned}}, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/rvj1_lsu.sv
// rvj1 load/store unit: one access at a time, all outputs registered.
// Optional RVJ1_LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses without a bus request.
module rvj1_lsu
    import rvj1_lsu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ctrl_valid_i,
    output logic                  ctrl_ready_o,
    input  logic                  ctrl_cmd_i,
    input  logic [1:0]            ctrl_size_i,
    input  logic                  ctrl_unsigned_i,
    input  logic [DATA_WIDTH-1:0] ctrl_addr_i,
    input  logic [DATA_WIDTH-1:0] ctrl_wdata_i,
    output logic                  rsp_valid_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  req_o,
    output logic [DATA_WIDTH-1:0] addr_o,
    output logic [3:0]            we_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic                  rvalid_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic                  wvalid_i,
    input  logic                  err_i
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e       state_reg, state_next;
    lsu_cmd_e         cmd_reg, cmd_next;
    lsu_size_e        size_reg, size_next;
    logic             uns_reg, uns_next;
    logic [1:0]       off_reg, off_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             ready_reg, ready_next;
    logic             req_reg, req_next;
    logic [31:0]      addr_reg, addr_next;
    logic [3:0]       we_reg, we_next;
    logic [31:0]      wdata_reg, wdata_next;
    logic             rsp_valid_reg, rsp_valid_next;
    logic             rsp_err_reg, rsp_err_next;
    logic [31:0]      rsp_rdata_reg, rsp_rdata_next;

    lsu_size_e        in_size;
    logic [3:0]       fmt_we;
    logic [31:0]      fmt_wdata;
    logic             misaligned;
    logic [31:0]      load_result;

    assign in_size = norm_size(ctrl_size_i);

    // Each byte lane carries the lane of the store data that lands there after replication.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign fmt_wdata[8*gi +: 8] = (in_size == LSU_B) ? ctrl_wdata_i[7:0] :
                                          (in_size == LSU_H) ? ctrl_wdata_i[8*(gi%2) +: 8] :
                                                               ctrl_wdata_i[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        case (in_size)
            LSU_B:   fmt_we = 4'b0001 << ctrl_addr_i[1:0];
            LSU_H:   fmt_we = 4'b0011 << {ctrl_addr_i[1], 1'b0};
            default: fmt_we = 4'hF;
        endcase
    end

`ifdef RVJ1_LSU_MISALIGN_CHECK_EN
    assign misaligned = ((in_size == LSU_H) && ctrl_addr_i[0]) ||
                        ((in_size == LSU_W) && (ctrl_addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    rvj1_lsu_load_align u_load_align (
        .rdata       (rdata_i),
        .offset      (off_reg),
        .size        (size_reg),
        .is_unsigned (uns_reg),
        .result      (load_result)
    );

    always_comb begin
        state_next     = state_reg;
        cmd_next       = cmd_reg;
        size_next      = size_reg;
        uns_next       = uns_reg;
        off_next       = off_reg;
        cnt_next       = cnt_reg;
        ready_next     = 1'b0;
        req_next       = 1'b0;
        addr_next      = '0;
        we_next        = '0;
        wdata_next     = '0;
        rsp_valid_next = 1'b0;
        rsp_err_next   = 1'b0;
        rsp_rdata_next = '0;
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_valid_i) begin
                    cmd_next  = lsu_cmd_e'(ctrl_cmd_i);
                    size_next = in_size;
                    uns_next  = ctrl_unsigned_i;
                    off_next  = ctrl_addr_i[1:0];
                    if (misaligned) begin
                        state_next     = ST_RESP;
                        rsp_valid_next = 1'b1;
                        rsp_err_next   = 1'b1;
                    end else begin
                        state_next = ST_REQ;
                        req_next   = 1'b1;
                        addr_next  = {ctrl_addr_i[31:2], 2'b00};
                        we_next    = ctrl_cmd_i ? fmt_we : 4'b0000;
                        wdata_next = fmt_wdata;
                    end
                end else begin
                    ready_next = 1'b1;
                end
            end
            ST_REQ: begin
                state_next = ST_WAIT;
                cnt_next   = '0;
            end
            ST_WAIT: begin
                // A bus error outranks data arriving in the same cycle.
                if (err_i) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                end else if ((cmd_reg == LSU_LOAD) && rvalid_i) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = 1'b1;
                    rsp_rdata_next = load_result;
                end else if ((cmd_reg == LSU_STORE) && wvalid_i) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = 1'b1;
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_next     = ST_RESP;
                    rsp_valid_next = 1'b1;
                    rsp_err_next   = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = ST_IDLE;
                ready_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg     <= ST_IDLE;
            cmd_reg       <= LSU_LOAD;
            size_reg      <= LSU_B;
            uns_reg       <= 1'b0;
            off_reg       <= 2'b00;
            cnt_reg       <= '0;
            ready_reg     <= 1'b1;
            req_reg       <= 1'b0;
            addr_reg      <= '0;
            we_reg        <= '0;
            wdata_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cmd_reg       <= cmd_next;
            size_reg      <= size_next;
            uns_reg       <= uns_next;
            off_reg       <= off_next;
            cnt_reg       <= cnt_next;
            ready_reg     <= ready_next;
            req_reg       <= req_next;
            addr_reg      <= addr_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_err_reg   <= rsp_err_next;
            rsp_rdata_reg <= rsp_rdata_next;
        end
    end

    assign ctrl_ready_o = ready_reg;
    assign req_o        = req_reg;
    assign addr_o       = addr_reg;
    assign we_o         = we_reg;
    assign wdata_o      = wdata_reg;
    assign rsp_valid_o  = rsp_valid_reg;
    assign rsp_err_o    = rsp_err_reg;
    assign rsp_rdata_o  = rsp_rdata_reg;

endmodule
